ysyx_25040101_exu_seq: RTL and testbench
========================================

# ysyx_25040101_exu_seq

Multi-cycle execute sequencer for the nebula core. Accepts one decoded instruction at a time from the IDU and steps it through EXEC, optional memory access, and write-back. It drives the ALU operand-select controls (srca/srcb muxes), the register-file and PC write enables, and the LSU request handshake. There is no overlap: one instruction completes before the next one is accepted.

## Interface
- `TMO_W`, default 8: width of the LSU response timeout counter.
- `TMO_MAX`, default 255: cycles spent in MEM_WAIT before a timeout; must satisfy 1 ≤ TMO_MAX < 2^TMO_W.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid_i`  in  1  IDU has a decoded instruction.
- `in_ready_o`  out  1  sequencer can accept an instruction.
- `cls_i`  in  3  instruction class: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 JUMP (JAL/JALR), 5 BRANCH, 6 AUIPC, 7 reserved.
- `srca_ctrl_o`  out  1  ALU operand A select: 0 rs1, 1 pc.
- `srcb_ctrl_o`  out  2  ALU operand B select: 00 rs2, 01 imm, 10 constant 4.
- `rf_wen_o`  out  1  register-file write strobe.
- `pc_wen_o`  out  1  PC update strobe.
- `lsu_req_valid_o`  out  1  LSU request valid.
- `lsu_wen_o`  out  1  1 = store, 0 = load; valid only while `lsu_req_valid_o` is high.
- `lsu_req_ready_i`  in  1  LSU accepts the request.
- `lsu_resp_valid_i`  in  1  LSU access complete.
- `err_o`  out  1  one-cycle pulse on a reserved class or an LSU timeout.

## Operation
- States: IDLE, EXEC, MEM_REQ, MEM_WAIT, WB.
- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i` & `in_ready_o`, latch `cls_i` into `cls_q` and go to EXEC.
- **EXEC** (1 cycle): drive the operand selects from `cls_q`.
  - ALU_R: srca 0, srcb 00.
  - ALU_I, LOAD, STORE: srca 0, srcb 01.
  - JUMP: srca 1, srcb 10 (link = pc+4).
  - BRANCH: srca 0, srcb 00.
  - AUIPC: srca 1, srcb 01.
  - Reserved: srca 0, srcb 00.
  - Next state: LOAD/STORE go to MEM_REQ; all other classes go to WB.
- **MEM_REQ**
  - Assert `lsu_req_valid_o`; `lsu_wen_o` = (cls_q == STORE).
  - Hold valid and `lsu_wen_o` stable until `lsu_req_ready_i`.
  - On handshake, go to MEM_WAIT and clear the timeout counter.
  - `lsu_resp_valid_i` is ignored in this state.
- **MEM_WAIT**
  - On `lsu_resp_valid_i`, go to WB.
  - Otherwise increment the counter; when the counter == TMO_MAX, go to WB with `tmo_q` set.
  - Response and timeout in the same cycle: the response wins and `tmo_q` stays clear.
- **WB** (1 cycle)
  - `pc_wen_o` = 1 always.
  - `rf_wen_o` = 1 for ALU_R, ALU_I, LOAD, JUMP, AUIPC, except LOAD with `tmo_q` set.
  - `err_o` = 1 if cls_q == 7 or `tmo_q` is set.
  - Next state IDLE; `tmo_q` clears.
- In MEM_REQ, MEM_WAIT and WB, srca/srcb hold their EXEC values.
- `reset` in any state:
  - next state IDLE; `cls_q`, counter and `tmo_q` cleared.
  - An outstanding LSU request is dropped; the LSU must also be reset.

## Timing
- Every output is 0 while `reset` is high, including `in_ready_o` and both selects.
- `in_ready_o` rises the cycle after `reset` falls.
- All outputs are Moore (decoded from registered state only); no input-to-output combinational paths.
- Latency from the accept edge to the WB cycle:
  - non-memory classes: 2 cycles;
  - memory classes: 3 + (ready wait) + (response wait) cycles.
- Minimum issue interval: 3 cycles (IDLE, EXEC, WB).
- Timeout: WB occurs TMO_MAX+1 cycles after entering MEM_WAIT.
- The counter never wraps; it saturates at TMO_MAX.

## Configuration
- Macro: `YSYX_25040101_LSU_TMO_EN`.
- Defined:
  - timeout counter instantiated;
  - behaviour as above.
- Undefined:
  - counter and `tmo_q` removed;
  - MEM_WAIT waits indefinitely for `lsu_resp_valid_i`;
  - `err_o` flags reserved classes only;
  - `TMO_W` and `TMO_MAX` are ignored.

## Structure
- Shared package `ysyx_25040101_pkg` holds:
  - class encodings;
  - srca/srcb select encodings, shared with the operand muxes and the decoder;
  - the state enum.
- One sub-module, `ysyx_25040101_tmo_cnt`: clear, enable, saturating count, `hit` output.
  - Instantiated only under the macro.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `in_ready_o` = 1 on the first cycle after release.
- ALU_R accepted at cycle t → EXEC at t+1 with srcb 00; WB at t+2 with `rf_wen_o` = `pc_wen_o` = 1; `in_ready_o` = 1 at t+3.
- JUMP → srca 1, srcb 10 in EXEC; `rf_wen_o` in WB. BRANCH → srcb 00, `rf_wen_o` = 0.
- STORE with `lsu_req_ready_i` low for 4 cycles, then response 2 cycles after the handshake:
  - `lsu_req_valid_o` and `lsu_wen_o` = 1 stable for 5 cycles;
  - WB with `rf_wen_o` = 0.
- LOAD with no response, TMO_MAX = 5 → WB 6 cycles after MEM_WAIT entry; `err_o` pulse; `rf_wen_o` = 0. Variant: response in the 6th cycle → no `err_o`, `rf_wen_o` = 1.
- `reset` asserted in MEM_WAIT → next cycle IDLE, all outputs 0; a following ALU_I completes normally with srcb 01.

Source files
------------

// File: rtl/ysyx_25040101_pkg.sv
// Shared encodings for the nebula execute sequencer:
// instruction classes, operand selects and sequencer states.
package ysyx_25040101_pkg;

  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'd0,
    CLS_ALU_I  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_AUIPC  = 3'd6,
    CLS_RSVD   = 3'd7
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_WB       = 3'd4
  } state_e;

  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       srca;
    logic [1:0] srcb;
  } src_sel_t;

  function automatic src_sel_t src_sel(cls_e c);
    src_sel_t s;
    s.srca = SRCA_RS1;
    s.srcb = SRCB_RS2;
    case (c)
      CLS_ALU_I, CLS_LOAD, CLS_STORE: s.srcb = SRCB_IMM;
      CLS_JUMP: begin
        s.srca = SRCA_PC;
        s.srcb = SRCB_FOUR;
      end
      CLS_AUIPC: begin
        s.srca = SRCA_PC;
        s.srcb = SRCB_IMM;
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic cls_writes_rd(cls_e c);
    case (c)
      CLS_ALU_R, CLS_ALU_I, CLS_LOAD,
      CLS_JUMP, CLS_AUIPC: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic cls_is_mem(cls_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/ysyx_25040101_tmo_cnt.sv
// Saturating LSU response timeout counter; hit_o flags
// that the count has reached TMO_MAX.
module ysyx_25040101_tmo_cnt #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TMO_W-1:0] MAX_V = TMO_W'(TMO_MAX);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != MAX_V) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == MAX_V);

endmodule

// File: rtl/ysyx_25040101_exu_seq.sv
// Multi-cycle execute sequencer: IDLE/EXEC/MEM_REQ/MEM_WAIT/WB.
// LSU timeout enabled by `define YSYX_25040101_LSU_TMO_EN.
module ysyx_25040101_exu_seq
  import ysyx_25040101_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [2:0] cls_i,
  output logic       srca_ctrl_o,
  output logic [1:0] srcb_ctrl_o,
  output logic       rf_wen_o,
  output logic       pc_wen_o,
  output logic       lsu_req_valid_o,
  output logic       lsu_wen_o,
  input  logic       lsu_req_ready_i,
  input  logic       lsu_resp_valid_i,
  output logic       err_o
);

  state_e   state_q, state_d;
  cls_e     cls_q, cls_d;
  logic     live_q, live_d;
  logic     tmo_hit;
  logic     tmo_flag;
  src_sel_t sel;

`ifdef YSYX_25040101_LSU_TMO_EN
  logic tmo_q, tmo_d;

  ysyx_25040101_tmo_cnt #(
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) u_tmo_cnt (
    .clock(clock),
    .reset(reset),
    .clr_i(state_q != S_MEM_WAIT),
    .en_i (state_q == S_MEM_WAIT && !lsu_resp_valid_i),
    .hit_o(tmo_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_flag = tmo_q;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = TMO_W'(TMO_MAX);
  assign tmo_hit    = 1'b0;
  assign tmo_flag   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    live_d  = 1'b1;
`ifdef YSYX_25040101_LSU_TMO_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i && live_q) begin
          cls_d   = cls_e'(cls_i);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = cls_is_mem(cls_q) ? S_MEM_REQ : S_WB;
      end
      S_MEM_REQ: begin
        if (lsu_req_ready_i) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid_i) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d = S_WB;
`ifdef YSYX_25040101_LSU_TMO_EN
          tmo_d   = 1'b1;
`endif
        end
      end
      S_WB: begin
        state_d = S_IDLE;
`ifdef YSYX_25040101_LSU_TMO_EN
        tmo_d   = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // live_q keeps in_ready_o low until the first edge after reset drops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_ALU_R;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      live_q  <= live_d;
    end
  end

  assign sel = src_sel(cls_q);

  always_comb begin
    in_ready_o      = live_q && (state_q == S_IDLE);
    srca_ctrl_o     = sel.srca;
    srcb_ctrl_o     = sel.srcb;
    lsu_req_valid_o = 1'b0;
    lsu_wen_o       = 1'b0;
    rf_wen_o        = 1'b0;
    pc_wen_o        = 1'b0;
    err_o           = 1'b0;
    if (state_q == S_MEM_REQ) begin
      lsu_req_valid_o = 1'b1;
      lsu_wen_o       = (cls_q == CLS_STORE);
    end
    if (state_q == S_WB) begin
      pc_wen_o = 1'b1;
      rf_wen_o = cls_writes_rd(cls_q)
              && !(cls_q == CLS_LOAD && tmo_flag);
      err_o    = (cls_q == CLS_RSVD) || tmo_flag;
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_exu_seq.sv
// Directed bench for ysyx_25040101_exu_seq; output bundle
// order: ready, srca, srcb[1:0], rf, pc, lsu_req, lsu_wen, err.
module tb_ysyx_25040101_exu_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [2:0] cls_i = 3'd0;
  logic       srca_ctrl_o;
  logic [1:0] srcb_ctrl_o;
  logic       rf_wen_o;
  logic       pc_wen_o;
  logic       lsu_req_valid_o;
  logic       lsu_wen_o;
  logic       lsu_req_ready_i = 1'b0;
  logic       lsu_resp_valid_i = 1'b0;
  logic       err_o;

  int n_vec = 0;
  int n_err = 0;

  ysyx_25040101_exu_seq #(
    .TMO_W  (8),
    .TMO_MAX(5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .cls_i           (cls_i),
    .srca_ctrl_o     (srca_ctrl_o),
    .srcb_ctrl_o     (srcb_ctrl_o),
    .rf_wen_o        (rf_wen_o),
    .pc_wen_o        (pc_wen_o),
    .lsu_req_valid_o (lsu_req_valid_o),
    .lsu_wen_o       (lsu_wen_o),
    .lsu_req_ready_i (lsu_req_ready_i),
    .lsu_resp_valid_i(lsu_resp_valid_i),
    .err_o           (err_o)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] outs();
    return {in_ready_o, srca_ctrl_o, srcb_ctrl_o, rf_wen_o,
            pc_wen_o, lsu_req_valid_o, lsu_wen_o, err_o};
  endfunction

  task automatic check(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic [2:0] c);
    in_valid_i = 1'b1;
    cls_i      = c;
    step();
    in_valid_i = 1'b0;
    cls_i      = 3'd0;
  endtask

  initial begin
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", outs(), 9'b0_0_00_0_0_0_0_0);
    end
    reset = 1'b0;
    step();
    check("rst_rel", outs(), 9'b1_0_00_0_0_0_0_0);

    issue(3'd0);
    check("alur_ex", outs(), 9'b0_0_00_0_0_0_0_0);
    step();
    check("alur_wb", outs(), 9'b0_0_00_1_1_0_0_0);
    step();
    check("alur_idl", outs(), 9'b1_0_00_0_0_0_0_0);

    issue(3'd4);
    check("jmp_ex", outs(), 9'b0_1_10_0_0_0_0_0);
    step();
    check("jmp_wb", outs(), 9'b0_1_10_1_1_0_0_0);
    step();
    check("jmp_idl", outs(), 9'b1_1_10_0_0_0_0_0);

    issue(3'd5);
    check("br_ex", outs(), 9'b0_0_00_0_0_0_0_0);
    step();
    check("br_wb", outs(), 9'b0_0_00_0_1_0_0_0);
    step();

    issue(3'd6);
    check("aui_ex", outs(), 9'b0_1_01_0_0_0_0_0);
    step();
    check("aui_wb", outs(), 9'b0_1_01_1_1_0_0_0);
    step();

    issue(3'd7);
    check("rsv_ex", outs(), 9'b0_0_00_0_0_0_0_0);
    step();
    check("rsv_wb", outs(), 9'b0_0_00_0_1_0_0_1);
    step();
    check("rsv_idl", outs(), 9'b1_0_00_0_0_0_0_0);

    issue(3'd3);
    check("st_ex", outs(), 9'b0_0_01_0_0_0_0_0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("st_req", outs(), 9'b0_0_01_0_0_1_1_0);
      lsu_resp_valid_i = (i == 1);
      lsu_req_ready_i  = (i == 4);
      step();
    end
    lsu_req_ready_i  = 1'b0;
    lsu_resp_valid_i = 1'b0;
    check("st_wait1", outs(), 9'b0_0_01_0_0_0_0_0);
    step();
    check("st_wait2", outs(), 9'b0_0_01_0_0_0_0_0);
    lsu_resp_valid_i = 1'b1;
    step();
    lsu_resp_valid_i = 1'b0;
    check("st_wb", outs(), 9'b0_0_01_0_1_0_0_0);
    step();
    check("st_idl", outs(), 9'b1_0_01_0_0_0_0_0);

`ifdef YSYX_25040101_LSU_TMO_EN
    issue(3'd2);
    check("ldt_ex", outs(), 9'b0_0_01_0_0_0_0_0);
    step();
    lsu_req_ready_i = 1'b1;
    check("ldt_req", outs(), 9'b0_0_01_0_0_1_0_0);
    step();
    lsu_req_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("ldt_wait", outs(), 9'b0_0_01_0_0_0_0_0);
      step();
    end
    check("ldt_wb", outs(), 9'b0_0_01_0_1_0_0_1);
    step();
    check("ldt_idl", outs(), 9'b1_0_01_0_0_0_0_0);

    issue(3'd2);
    step();
    lsu_req_ready_i = 1'b1;
    step();
    lsu_req_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("ldr_wait", outs(), 9'b0_0_01_0_0_0_0_0);
      lsu_resp_valid_i = (i == 5);
      step();
    end
    lsu_resp_valid_i = 1'b0;
    check("ldr_wb", outs(), 9'b0_0_01_1_1_0_0_0);
    step();
`else
    issue(3'd2);
    step();
    lsu_req_ready_i = 1'b1;
    step();
    lsu_req_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("ldn_wait", outs(), 9'b0_0_01_0_0_0_0_0);
      lsu_resp_valid_i = (i == 8);
      step();
    end
    lsu_resp_valid_i = 1'b0;
    check("ldn_wb", outs(), 9'b0_0_01_1_1_0_0_0);
    step();
`endif

    issue(3'd2);
    step();
    lsu_req_ready_i = 1'b1;
    step();
    lsu_req_ready_i = 1'b0;
    check("rmw_wait", outs(), 9'b0_0_01_0_0_0_0_0);
    reset = 1'b1;
    step();
    check("rmw_rst", outs(), 9'b0_0_00_0_0_0_0_0);
    reset = 1'b0;
    step();
    check("rmw_idl", outs(), 9'b1_0_00_0_0_0_0_0);
    issue(3'd1);
    check("alui_ex", outs(), 9'b0_0_01_0_0_0_0_0);
    step();
    check("alui_wb", outs(), 9'b0_0_01_1_1_0_0_0);
    step();
    check("alui_idl", outs(), 9'b1_0_01_0_0_0_0_0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
